bios_mem_loader: RTL and testbench

- Writer side of the BIOS/instruction memory. Receives a framed byte stream from the UART receiver over a ready/valid byte interface.
- Assembles little-endian 32-bit words and writes them through the memory's synchronous write port (en, 4-bit we, word addr, din).
- Lets host software place a program image in the memory that the CPU later fetches from. Sits between the UART RX and the memory write port.

---
 rtl/bios_mem_loader.sv | 179 +++++++++++++++++
 tb/tb_bios_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_mem_loader.sv
// bios_mem_loader: receives a framed byte stream over a ready/valid byte
// interface, assembles little-endian 32-bit words and writes them through a
// synchronous word-wide memory write port.
// Frame: SYNC, 4-byte byte address, 2-byte word count N, N*4 data bytes,
// then a 1-byte checksum (mod-256 sum of all data bytes).
module bios_mem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [1:0]            r_idx;      // byte index within the current field
  logic [31:0]           r_addr;     // byte address A from the header
  logic [15:0]           r_count;    // words remaining in the frame
  logic [ADDR_WIDTH-1:0] r_ptr;      // next word address to write
  logic [31:0]           r_word;     // word under assembly
  logic [7:0]            r_sum;      // running checksum of data bytes

  logic                  r_mem_en;
  logic [3:0]            r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_din;
  logic                  r_done;
  logic                  r_error;

  logic                  w_ready;
  logic                  w_busy;
  logic                  w_xfer;
  logic [15:0]           w_count_full;
  logic [31:0]           w_word_next;

  assign w_xfer       = in_valid && w_ready;
  // Full word count as it will look once the high byte lands this cycle.
  assign w_count_full = {in_data, r_count[7:0]};

  // Word under assembly with the incoming byte dropped into its lane.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_word_next               = r_word;
    w_word_next[8*r_idx +: 8] = in_data;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: field sequencing driven by accepted bytes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && in_data == SYNC_BYTE) w_next = S_ADDR;
      S_ADDR:  if (w_xfer && r_idx == 2'd3)        w_next = S_COUNT;
      S_COUNT: if (w_xfer && r_idx == 2'd1)
                 w_next = (w_count_full == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:  if (w_xfer && r_idx == 2'd3)        w_next = S_WRITE;
      S_WRITE: w_next = (r_count == 16'd1) ? S_CSUM : S_DATA;
      S_CSUM:  if (w_xfer)                         w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: stall the source only during the write cycle.
  always_comb begin
    w_ready = (r_state != S_WRITE);
    w_busy  = (r_state != S_IDLE);
  end

  // Datapath: header capture, word assembly, checksum, registered memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_ptr      <= '0;
      r_word     <= '0;
      r_sum      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 4'h0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // Strobes are high exactly while the state register holds WRITE.
      r_mem_en <= (w_next == S_WRITE);
      r_mem_we <= (w_next == S_WRITE) ? 4'hF : 4'h0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && in_data == SYNC_BYTE) begin
            r_idx <= '0;
            r_sum <= '0;
          end
        end
        S_ADDR: begin
          if (w_xfer) begin
            r_addr[8*r_idx +: 8] <= in_data;
            r_idx                <= r_idx + 2'd1;  // wraps to 0 for COUNT
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            r_count[8*r_idx[0] +: 8] <= in_data;
            if (r_idx == 2'd1) begin
              r_idx <= '0;
              // Byte offset and bits beyond the memory size are dropped.
              r_ptr <= r_addr[ADDR_WIDTH+1:2];
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= w_word_next;
            r_sum  <= r_sum + in_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_mem_addr <= r_ptr;
              r_mem_din  <= w_word_next;
            end
          end
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + ADDR_WIDTH'(1);  // wraps freely at the top
          r_count <= r_count - 16'd1;
          r_idx   <= '0;
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_done  <= (in_data == r_sum);
            r_error <= (in_data != r_sum);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = w_ready;
  assign busy     = w_busy;
  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_bios_mem_loader.sv
// Testbench for bios_mem_loader: directed frames plus randomized frames with
// random idle gaps, checked against a frame-level parser model.
module tb_bios_mem_loader;

  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          busy;
  logic          done;
  logic          error;

  bios_mem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'h55)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte stream under construction, and the model's expectations for it.
  bit [7:0]        stream[$];
  bit [AW+31:0]    exp_q[$];
  int              exp_done;
  int              exp_err;
  bit [7:0]        gen_sum;

  // Observed memory writes and pulses.
  bit [AW+31:0]    obs_q[$];
  int              obs_done;
  int              obs_err;
  int              we_bad;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        obs_q.push_back({mem_addr, mem_din});
        if (mem_we !== 4'hF) we_bad++;
      end else if (mem_we !== 4'h0) begin
        we_bad++;
      end
      if (done)  obs_done++;
      if (error) obs_err++;
    end
  end

  // Frame-level parser: find SYNC, read header, list writes, judge checksum.
  task automatic ref_model(input bit [7:0] s[$]);
    int        i;
    bit [31:0] a;
    int        n;
    int        ptr;
    int        sum;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    i = 0;
    while (i < s.size() && s[i] != 8'h55) i++;
    i++;
    a   = {s[i+3], s[i+2], s[i+1], s[i]};
    i  += 4;
    n   = int'({s[i+1], s[i]});
    i  += 2;
    ptr = int'((a >> 2) % (1 << AW));
    sum = 0;
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({AW'(ptr), s[i+3], s[i+2], s[i+1], s[i]});
      sum = (sum + s[i] + s[i+1] + s[i+2] + s[i+3]) % 256;
      ptr = (ptr + 1) % (1 << AW);
      i  += 4;
    end
    if (int'(s[i]) == sum) exp_done = 1;
    else                   exp_err  = 1;
  endtask

  task automatic push_hdr(input bit [31:0] a, input bit [15:0] n);
    stream.push_back(8'h55);
    for (int k = 0; k < 4; k++) stream.push_back(a[8*k +: 8]);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    gen_sum = 8'h00;
  endtask

  task automatic push_word(input bit [31:0] w);
    for (int k = 0; k < 4; k++) begin
      stream.push_back(w[8*k +: 8]);
      gen_sum += w[8*k +: 8];
    end
  endtask

  task automatic push_garbage(input int cnt);
    bit [7:0] g;
    for (int k = 0; k < cnt; k++) begin
      g = 8'($urandom);
      if (g == 8'h55) g = 8'h54;
      stream.push_back(g);
    end
  endtask

  // Present one byte with a random idle gap; hold it until accepted.
  task automatic send_byte(input bit [7:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_done = 0;
    obs_err  = 0;
    we_bad   = 0;
  endtask

  // Send the whole stream and compare against the model.
  task automatic run_frame(input string name);
    int m;
    ref_model(stream);
    clear_obs();
    foreach (stream[k]) send_byte(stream[k]);
    repeat (4) @(negedge clk);
    check({name, ".nwr"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < m; k++)
      check($sformatf("%s.wr%0d", name, k), obs_q[k], exp_q[k]);
    check({name, ".done"}, obs_done, exp_done);
    check({name, ".err"}, obs_err, exp_err);
    check({name, ".we"}, we_bad, 0);
    check({name, ".busy"}, busy, 0);
    check({name, ".rdy"}, in_ready, 1);
    stream.delete();
  endtask

  // Scenario-1 frame; checksum 0x75 is the mod-256 sum of its eight data bytes.
  task automatic push_frame1(input bit [7:0] csum);
    push_hdr(32'h0000_0000, 16'd2);
    push_word(32'h0640_0093);
    push_word(32'h0000_0597);
    stream.push_back(csum);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #23;
    check("rst.rdy",  in_ready, 1);
    check("rst.en",   mem_en,   0);
    check("rst.we",   mem_we,   0);
    check("rst.addr", mem_addr, 0);
    check("rst.din",  mem_din,  0);
    check("rst.busy", busy,     0);
    check("rst.done", done,     0);
    check("rst.err",  error,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Good checksum: two writes, done.
    push_frame1(8'h75);
    run_frame("good");
    if (obs_q.size() == 2) begin
      check("good.w0", obs_q[0], {12'h000, 32'h0640_0093});
      check("good.w1", obs_q[1], {12'h001, 32'h0000_0597});
    end
    check("good.done_once", obs_done, 1);

    // Bad checksum: writes still happen, error pulses.
    push_frame1(8'h00);
    run_frame("badcs");
    check("badcs.err_once", obs_err, 1);

    // Leading garbage is discarded and does not start a frame.
    clear_obs();
    stream.push_back(8'h00);
    stream.push_back(8'hFF);
    stream.push_back(8'h12);
    foreach (stream[k]) begin
      send_byte(stream[k]);
      @(negedge clk);
      check($sformatf("garb.busy%0d", k), busy, 0);
    end
    check("garb.nwr", obs_q.size(), 0);
    stream.delete();
    push_frame1(8'h75);
    run_frame("aftergarb");

    // Pointer wraps from the top word to zero.
    push_hdr(32'h0000_3FFC, 16'd2);
    push_word($urandom);
    push_word($urandom);
    stream.push_back(gen_sum);
    run_frame("wrap");
    if (obs_q.size() == 2) begin
      check("wrap.a0", obs_q[0][AW+31:32], 12'hFFF);
      check("wrap.a1", obs_q[1][AW+31:32], 12'h000);
    end

    // Empty frame: no writes, done.
    push_hdr(32'h0000_0100, 16'd0);
    stream.push_back(8'h00);
    run_frame("empty");

    // Reset after the second data byte.
    clear_obs();
    push_frame1(8'h75);
    for (int k = 0; k < 9; k++) send_byte(stream[k]);
    rst_n = 1'b0;
    #1;
    check("midrst.en",   mem_en,   0);
    check("midrst.we",   mem_we,   0);
    check("midrst.busy", busy,     0);
    check("midrst.rdy",  in_ready, 1);
    stream.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_hdr(32'h0000_0040, 16'd3);
    for (int k = 0; k < 3; k++) push_word($urandom);
    stream.push_back(gen_sum);
    run_frame("postrst");

    // Reset during the write cycle clears the strobes asynchronously.
    clear_obs();
    push_frame1(8'h75);
    for (int k = 0; k < 11; k++) send_byte(stream[k]);
    check("wrrst.pre_en", mem_en, 1);
    rst_n = 1'b0;
    #1;
    check("wrrst.en",   mem_en, 0);
    check("wrrst.we",   mem_we, 0);
    check("wrrst.busy", busy,   0);
    stream.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      int  n;
      bit  good;
      push_garbage($urandom_range(0, 3));
      n    = $urandom_range(0, 4);
      good = ($urandom_range(0, 3) != 0);
      push_hdr($urandom, 16'(n));
      for (int w = 0; w < n; w++) push_word($urandom);
      stream.push_back(good ? gen_sum : gen_sum + 8'(1 + $urandom_range(0, 254)));
      run_frame($sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
